// File: rtl/fft_frame_sequencer.sv
// Frame sequencer / config controller in front of an FFT core.
// Issues one config word per run, slices the sample stream into
// FRAME_LEN-sample frames with tlast, caps the number of frames in flight,
// and counts completed spectra by watching the magnitude output stream.
module fft_frame_sequencer #(
    parameter int LOG2_LEN     = 10,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        I_CLOCK,
    input  logic        I_RESETN,
    input  logic        I_START,
    input  logic        I_STOP,
    input  logic        I_CFG_FWD,
    input  logic        S_I_DATA_VALID,
    output logic        S_O_DATA_READY,
    input  logic [31:0] S_I_DATA,
    output logic        F_O_CFG_VALID,
    input  logic        F_I_CFG_READY,
    output logic [15:0] F_O_CFG_DATA,
    output logic        F_O_DATA_VALID,
    input  logic        F_I_DATA_READY,
    output logic [31:0] F_O_DATA,
    output logic        F_O_DATA_LAST,
    input  logic        M_I_DATA_VALID,
    input  logic        M_I_DATA_READY,
    output logic        O_BUSY,
    output logic        O_FRAME_DONE,
    output logic [15:0] O_FRAMES_OUT,
    output logic        O_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_STREAM, S_DRAIN} state_t;

    localparam logic [LOG2_LEN-1:0] CNT_LAST = '1;
    localparam logic [2:0]          INFL_MAX = 3'(MAX_INFLIGHT);

    state_t              state_q, state_d;
    logic                fwd_q, fwd_d;
    logic                stop_q, stop_d;
    logic [LOG2_LEN-1:0] in_cnt_q, in_cnt_d;
    logic [LOG2_LEN-1:0] out_cnt_q, out_cnt_d;
    logic [2:0]          inflight_q, inflight_d;
    logic [15:0]         frames_q, frames_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic gate, in_hs, last_hs, m_beat, out_hs, frame_out;

    // Data gate and handshake qualifiers; a frame already started is never
    // throttled, only a new frame waits for an in-flight slot.
    always_comb begin
        gate      = (state_q == S_STREAM) &&
                    ((in_cnt_q != '0) || (inflight_q < INFL_MAX));
        in_hs     = S_I_DATA_VALID & F_I_DATA_READY & gate;
        last_hs   = in_hs && (in_cnt_q == CNT_LAST);
        m_beat    = M_I_DATA_VALID & M_I_DATA_READY;
        out_hs    = m_beat && (inflight_q != '0);
        frame_out = out_hs && (out_cnt_q == CNT_LAST);
    end

    // Input/output beat counters, in-flight tracking and completion stats.
    always_comb begin
        in_cnt_d   = in_hs  ? in_cnt_q + 1'b1  : in_cnt_q;
        out_cnt_d  = out_hs ? out_cnt_q + 1'b1 : out_cnt_q;
        inflight_d = inflight_q;
        case ({last_hs, frame_out})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
        frames_d = frame_out ? frames_q + 16'd1 : frames_q;
        done_d   = frame_out;
        err_d    = err_q | (m_beat && (inflight_q == '0));
    end

    // Run-control FSM: IDLE -> CONFIG -> STREAM -> DRAIN -> IDLE.
    always_comb begin
        state_d = state_q;
        fwd_d   = fwd_q;
        stop_d  = stop_q;
        case (state_q)
            S_IDLE: begin
                if (I_START) begin
                    state_d = S_CONFIG;
                    fwd_d   = I_CFG_FWD;
                    stop_d  = I_STOP;
                end
            end
            S_CONFIG: begin
                stop_d = stop_q | I_STOP;
                if (F_I_CFG_READY) state_d = S_STREAM;
            end
            S_STREAM: begin
                stop_d = stop_q | I_STOP;
                if (stop_d && (in_cnt_d == '0)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                stop_d = stop_q | I_STOP;
                if (inflight_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any partial or in-flight frames.
    always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state_q    <= S_IDLE;
            fwd_q      <= 1'b0;
            stop_q     <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= '0;
            frames_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fwd_q      <= fwd_d;
            stop_q     <= stop_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            frames_q   <= frames_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign F_O_CFG_VALID  = (state_q == S_CONFIG);
    assign F_O_CFG_DATA   = {15'b0, fwd_q};
    assign F_O_DATA_VALID = S_I_DATA_VALID & gate;
    assign S_O_DATA_READY = F_I_DATA_READY & gate;
    assign F_O_DATA       = S_I_DATA;
    assign F_O_DATA_LAST  = gate && (in_cnt_q == CNT_LAST);
    assign O_BUSY         = (state_q != S_IDLE);
    assign O_FRAME_DONE   = done_q;
    assign O_FRAMES_OUT   = frames_q;
    assign O_ERR          = err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer with a behavioural reference model
// (LOG2_LEN = 3, MAX_INFLIGHT = 2).
module tb_fft_frame_sequencer;

    localparam int LEN  = 8;
    localparam int MAXF = 2;

    logic        I_CLOCK = 1'b0;
    logic        I_RESETN = 1'b0;
    logic        I_START = 1'b0, I_STOP = 1'b0, I_CFG_FWD = 1'b0;
    logic        S_I_DATA_VALID = 1'b0;
    logic        S_O_DATA_READY;
    logic [31:0] S_I_DATA = '0;
    logic        F_O_CFG_VALID;
    logic        F_I_CFG_READY = 1'b0;
    logic [15:0] F_O_CFG_DATA;
    logic        F_O_DATA_VALID;
    logic        F_I_DATA_READY = 1'b0;
    logic [31:0] F_O_DATA;
    logic        F_O_DATA_LAST;
    logic        M_I_DATA_VALID = 1'b0, M_I_DATA_READY = 1'b0;
    logic        O_BUSY, O_FRAME_DONE, O_ERR;
    logic [15:0] O_FRAMES_OUT;

    fft_frame_sequencer #(.LOG2_LEN(3), .MAX_INFLIGHT(MAXF)) dut (
        .I_CLOCK(I_CLOCK), .I_RESETN(I_RESETN), .I_START(I_START), .I_STOP(I_STOP),
        .I_CFG_FWD(I_CFG_FWD), .S_I_DATA_VALID(S_I_DATA_VALID),
        .S_O_DATA_READY(S_O_DATA_READY), .S_I_DATA(S_I_DATA),
        .F_O_CFG_VALID(F_O_CFG_VALID), .F_I_CFG_READY(F_I_CFG_READY),
        .F_O_CFG_DATA(F_O_CFG_DATA), .F_O_DATA_VALID(F_O_DATA_VALID),
        .F_I_DATA_READY(F_I_DATA_READY), .F_O_DATA(F_O_DATA),
        .F_O_DATA_LAST(F_O_DATA_LAST), .M_I_DATA_VALID(M_I_DATA_VALID),
        .M_I_DATA_READY(M_I_DATA_READY), .O_BUSY(O_BUSY),
        .O_FRAME_DONE(O_FRAME_DONE), .O_FRAMES_OUT(O_FRAMES_OUT), .O_ERR(O_ERR)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: run phase plus plain integer counters.
    localparam int P_IDLE = 0, P_CFG = 1, P_RUN = 2, P_DRAIN = 3;
    int phase, m_fwd, m_stop, m_in, m_out, m_infl, m_frames, m_done, m_err;

    function automatic void model_reset();
        phase = P_IDLE; m_fwd = 0; m_stop = 0; m_in = 0; m_out = 0;
        m_infl = 0; m_frames = 0; m_done = 0; m_err = 0;
    endfunction

    function automatic bit model_gate();
        return (phase == P_RUN) && (m_in != 0 || m_infl < MAXF);
    endfunction

    // Compare every output against the model for the current inputs, then
    // advance the model by one clock and wait for the next falling edge.
    task automatic tick();
        bit g, ihs, lhs, mb, ohs, fo;
        int infl_old;
        #1;
        g = model_gate();
        chk("cfg_valid", F_O_CFG_VALID, phase == P_CFG);
        chk("cfg_data",  F_O_CFG_DATA, m_fwd);
        chk("busy",      O_BUSY, phase != P_IDLE);
        chk("d_valid",   F_O_DATA_VALID, S_I_DATA_VALID & g);
        chk("s_ready",   S_O_DATA_READY, F_I_DATA_READY & g);
        chk("last",      F_O_DATA_LAST, g && m_in == LEN - 1);
        chk("data",      F_O_DATA, S_I_DATA);
        chk("done",      O_FRAME_DONE, m_done);
        chk("frames",    O_FRAMES_OUT, m_frames);
        chk("err",       O_ERR, m_err);
        ihs = S_I_DATA_VALID && F_I_DATA_READY && g;
        lhs = ihs && m_in == LEN - 1;
        mb  = M_I_DATA_VALID && M_I_DATA_READY;
        ohs = mb && m_infl > 0;
        fo  = ohs && m_out == LEN - 1;
        infl_old = m_infl;
        if (mb && m_infl == 0) m_err = 1;
        if (ihs) m_in = (m_in + 1) % LEN;
        if (ohs) m_out = (m_out + 1) % LEN;
        m_infl = m_infl + int'(lhs) - int'(fo);
        m_frames = (m_frames + int'(fo)) % 65536;
        m_done = fo;
        case (phase)
            P_IDLE: if (I_START) begin phase = P_CFG; m_fwd = I_CFG_FWD; m_stop = I_STOP; end
            P_CFG: begin m_stop = m_stop | I_STOP; if (F_I_CFG_READY) phase = P_RUN; end
            P_RUN: begin m_stop = m_stop | I_STOP; if (m_stop && m_in == 0) phase = P_DRAIN; end
            default: begin m_stop = m_stop | I_STOP; if (infl_old == 0) phase = P_IDLE; end
        endcase
        @(negedge I_CLOCK);
    endtask

    task automatic rnd_cycle(input bit feed_m);
        S_I_DATA_VALID = ($urandom % 4) != 0;
        F_I_DATA_READY = ($urandom % 4) != 0;
        S_I_DATA       = $urandom;
        M_I_DATA_VALID = feed_m && m_infl > 0 && ($urandom % 2);
        M_I_DATA_READY = ($urandom % 3) != 0;
        tick();
    endtask

    task automatic run_to_idle(input string tag);
        int n = 0;
        while (phase != P_IDLE && n < 2000) begin rnd_cycle(1'b1); n++; end
        chk(tag, phase == P_IDLE, 1);
        chk({tag, "_busy"}, O_BUSY, 0);
    endtask

    task automatic start_run(input bit fwd);
        I_START = 1'b1; I_CFG_FWD = fwd; F_I_CFG_READY = 1'b1;
        tick();
        I_START = 1'b0; I_CFG_FWD = 1'b0;
        tick();
    endtask

    initial begin
        int cfg_cycles, frames0, n;
        model_reset();
        @(negedge I_CLOCK);
        S_I_DATA_VALID = 1'b1; F_I_DATA_READY = 1'b1;
        #1;
        chk("rst_busy", O_BUSY, 0);
        chk("rst_dvalid", F_O_DATA_VALID, 0);
        chk("rst_sready", S_O_DATA_READY, 0);
        chk("rst_cfg", {F_O_CFG_VALID, F_O_CFG_DATA}, 0);
        @(negedge I_CLOCK);
        I_RESETN = 1'b1;
        S_I_DATA_VALID = 1'b0;
        tick();

        // Config handshake held off 5 cycles.
        I_START = 1'b1; I_CFG_FWD = 1'b1; F_I_CFG_READY = 1'b0;
        tick();
        I_START = 1'b0; I_CFG_FWD = 1'b0;
        cfg_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            F_I_CFG_READY = (i == 5);
            #1 if (F_O_CFG_VALID) cfg_cycles++;
            chk("cfg_word", F_O_CFG_DATA, 16'h0001);
            tick();
        end
        chk("cfg_cycles", cfg_cycles, 6);
        chk("in_stream", F_O_CFG_VALID, 0);

        // Continuous stream fills both in-flight slots then stalls.
        S_I_DATA_VALID = 1'b1; F_I_DATA_READY = 1'b1;
        for (int i = 0; i < 24; i++) begin S_I_DATA = $urandom; tick(); end
        #1 chk("stalled", S_O_DATA_READY, 0);
        chk("model_infl", m_infl, MAXF);

        // Drain one frame of results with random ready stalls.
        S_I_DATA_VALID = 1'b0;
        n = 0;
        while (m_frames == 0 && n < 200) begin
            M_I_DATA_VALID = 1'b1; M_I_DATA_READY = ($urandom % 3) != 0;
            tick(); n++;
        end
        M_I_DATA_VALID = 1'b0;
        chk("first_frame", O_FRAME_DONE, 1);
        tick();
        chk("frames_one", O_FRAMES_OUT, 1);

        // Random traffic, then a stop mid-frame.
        for (int i = 0; i < 300; i++) rnd_cycle(1'b1);
        n = 0;
        while (!(phase == P_RUN && m_in == 3) && n < 500) begin rnd_cycle(1'b1); n++; end
        I_STOP = 1'b1; rnd_cycle(1'b1); I_STOP = 1'b0;
        run_to_idle("stop_idle");

        // Start and stop together: no samples, straight through to idle.
        frames0 = m_frames;
        S_I_DATA_VALID = 1'b0; M_I_DATA_VALID = 1'b0;
        I_START = 1'b1; I_STOP = 1'b1; I_CFG_FWD = 1'b0; F_I_CFG_READY = 1'b1;
        tick();
        I_START = 1'b0; I_STOP = 1'b0;
        n = 0;
        while (phase != P_IDLE && n < 20) begin tick(); n++; end
        chk("ss_idle", O_BUSY, 0);
        chk("ss_frames", O_FRAMES_OUT, frames0);

        // Result beat with nothing in flight.
        M_I_DATA_VALID = 1'b1; M_I_DATA_READY = 1'b1;
        tick();
        M_I_DATA_VALID = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("err_sticky", O_ERR, 1);
        chk("err_frames", O_FRAMES_OUT, frames0);

        // New run, then asynchronous reset in the middle of a frame.
        start_run(1'b1);
        for (int i = 0; i < 60; i++) rnd_cycle(1'b1);
        n = 0;
        while (!(phase == P_RUN && m_in != 0) && n < 200) begin rnd_cycle(1'b1); n++; end
        S_I_DATA_VALID = 1'b1; F_I_DATA_READY = 1'b1;
        #2 I_RESETN = 1'b0;
        #1;
        chk("arst_busy", O_BUSY, 0);
        chk("arst_dvalid", F_O_DATA_VALID, 0);
        chk("arst_sready", S_O_DATA_READY, 0);
        chk("arst_last", F_O_DATA_LAST, 0);
        chk("arst_frames", O_FRAMES_OUT, 0);
        chk("arst_err", O_ERR, 0);
        chk("arst_cfg", {F_O_CFG_VALID, F_O_CFG_DATA}, 0);
        chk("arst_done", O_FRAME_DONE, 0);
        model_reset();
        @(negedge I_CLOCK);
        I_RESETN = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
